// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// reg_file_if : write port and two read ports of the reg_file register bank
// Revision    : 1.0
// ============================================================================
interface reg_file_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic              rvalid_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic              rvalid_b;

  modport master (
    output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// reg_file : DEPTH x WIDTH register bank, 1 write / 2 registered read ports
//            with write-first bypass. Option macro: REG_FILE_ZERO_R0_EN.
// Revision : 1.0
// ============================================================================
module reg_file #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  reg_file_if.slave bus
);
`ifdef REG_FILE_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif
  localparam int              SLOTS   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Every addressable slot exists; slots without storage read as zero.
  logic [WIDTH-1:0] words [SLOTS];
  logic             wr_ok;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  assign wr_ok = bus.we && ({1'b0, bus.waddr} < DEPTH_L);

  for (genvar i = 0; i < SLOTS; i++) begin : g_mem
    if (i >= DEPTH || (ZERO_R0 && i == 0)) begin : g_const
      assign words[i] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] q;
      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else if (wr_ok && bus.waddr == ADDR_W'(i)) begin
          q <= bus.wdata;
        end
      end
      assign words[i] = q;
    end
  end

  // wr_ok already implies an in-range write address, so a hit is in range too.
  function automatic logic [WIDTH-1:0] pick(
    input logic [ADDR_W-1:0] ra,
    input logic              wok,
    input logic [ADDR_W-1:0] wa,
    input logic [WIDTH-1:0]  wd,
    input logic [WIDTH-1:0]  stored
  );
    logic hit;
    hit = wok && (wa == ra) && !(ZERO_R0 && ra == '0);
    return hit ? wd : stored;
  endfunction

  assign sel_a = pick(bus.raddr_a, wr_ok, bus.waddr, bus.wdata, words[bus.raddr_a]);
  assign sel_b = pick(bus.raddr_b, wr_ok, bus.waddr, bus.wdata, words[bus.raddr_b]);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata_a  <= '0;
      bus.rvalid_a <= 1'b0;
      bus.rdata_b  <= '0;
      bus.rvalid_b <= 1'b0;
    end else begin
      bus.rvalid_a <= bus.re_a;
      bus.rvalid_b <= bus.re_b;
      if (bus.re_a) begin
        bus.rdata_a <= sel_a;
      end
      if (bus.re_b) begin
        bus.rdata_b <= sel_b;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// tb_reg_file : directed self-checking bench for reg_file (DEPTH 4 and 3)
// Revision    : 1.0
// ============================================================================
module tb_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

`ifdef REG_FILE_ZERO_R0_EN
  localparam logic [7:0] R0_BYP = 8'h00;
  localparam logic [7:0] R0_3   = 8'h00;
`else
  localparam logic [7:0] R0_BYP = 8'h12;
  localparam logic [7:0] R0_3   = 8'h01;
`endif

  always #5 clk = ~clk;

  reg_file_if #(.WIDTH(8), .ADDR_W(2)) bus4 ();
  reg_file_if #(.WIDTH(8), .ADDR_W(2)) bus3 ();

  reg_file #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  reg_file #(.WIDTH(8), .DEPTH(3), .ADDR_W(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                      input logic ra_en, input logic [1:0] ra,
                      input logic rb_en, input logic [1:0] rb);
    bus4.we = we; bus4.waddr = wa; bus4.wdata = wd;
    bus4.re_a = ra_en; bus4.raddr_a = ra;
    bus4.re_b = rb_en; bus4.raddr_b = rb;
  endtask

  task automatic set3(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                      input logic ra_en, input logic [1:0] ra,
                      input logic rb_en, input logic [1:0] rb);
    bus3.we = we; bus3.waddr = wa; bus3.wdata = wd;
    bus3.re_a = ra_en; bus3.raddr_a = ra;
    bus3.re_b = rb_en; bus3.raddr_b = rb;
  endtask

  initial begin
    set4(0, 0, 0, 0, 0, 0, 0);
    set3(0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    check("init_rdata_a", bus4.rdata_a, 8'h00);
    check("init_rvalid_a", bus4.rvalid_a, 1'b0);
    check("init_rvalid_b", bus4.rvalid_b, 1'b0);
    rst = 1'b0;

    // Arbitrary contents, then reset with everything else asserted
    set4(1, 0, 8'h11, 0, 0, 0, 0); cyc();
    set4(1, 3, 8'h22, 0, 0, 0, 0); cyc();
    set4(1, 1, 8'h33, 1, 3, 1, 0); cyc();
    check("pre_rst_rdata_a", bus4.rdata_a, 8'h22);
    check("pre_rst_rdata_b", bus4.rdata_b, R0_BYP == 8'h00 ? 8'h00 : 8'h11);
    rst = 1'b1;
    set4(1, 2, 8'hAA, 1, 3, 1, 0); cyc();
    rst = 1'b0;
    check("rst_rdata_a", bus4.rdata_a, 8'h00);
    check("rst_rdata_b", bus4.rdata_b, 8'h00);
    check("rst_rvalid_a", bus4.rvalid_a, 1'b0);
    check("rst_rvalid_b", bus4.rvalid_b, 1'b0);
    set4(0, 0, 0, 1, 0, 1, 1); cyc();
    check("rst_mem0", bus4.rdata_a, 8'h00);
    check("rst_mem1", bus4.rdata_b, 8'h00);
    check("rst_rd_rvalid_a", bus4.rvalid_a, 1'b1);
    set4(0, 0, 0, 1, 2, 1, 3); cyc();
    check("rst_mem2", bus4.rdata_a, 8'h00);
    check("rst_mem3", bus4.rdata_b, 8'h00);

    // Write then read on both ports
    set4(1, 1, 8'h5A, 0, 0, 0, 0); cyc();
    set4(1, 2, 8'hC3, 0, 0, 0, 0); cyc();
    set4(0, 0, 0, 1, 1, 1, 2); cyc();
    check("wr_rdata_a", bus4.rdata_a, 8'h5A);
    check("wr_rdata_b", bus4.rdata_b, 8'hC3);
    check("wr_rvalid_a", bus4.rvalid_a, 1'b1);
    check("wr_rvalid_b", bus4.rvalid_b, 1'b1);

    // Hold while reads are disabled and addr 1 is overwritten
    set4(1, 1, 8'hFF, 0, 1, 0, 2);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("hold_rdata_a", bus4.rdata_a, 8'h5A);
      check("hold_rdata_b", bus4.rdata_b, 8'hC3);
      check("hold_rvalid_a", bus4.rvalid_a, 1'b0);
      check("hold_rvalid_b", bus4.rvalid_b, 1'b0);
    end
    set4(0, 0, 0, 1, 1, 0, 0); cyc();
    check("hold_written", bus4.rdata_a, 8'hFF);
    check("hold_b_idle", bus4.rvalid_b, 1'b0);

    // Same-cycle write/read bypass on both ports
    set4(1, 3, 8'h77, 1, 3, 1, 3); cyc();
    check("byp_rdata_a", bus4.rdata_a, 8'h77);
    check("byp_rdata_b", bus4.rdata_b, 8'h77);
    set4(0, 0, 0, 1, 3, 0, 0); cyc();
    check("byp_later", bus4.rdata_a, 8'h77);

    // Zero register (bypass when the option is off)
    set4(1, 0, 8'h12, 1, 0, 0, 0); cyc();
    check("r0_bypass", bus4.rdata_a, R0_BYP);
    set4(0, 0, 0, 1, 0, 1, 0); cyc();
    check("r0_later_a", bus4.rdata_a, R0_BYP);
    check("r0_later_b", bus4.rdata_b, R0_BYP);
    set4(0, 0, 0, 0, 0, 0, 0);

    // Out of range on the DEPTH=3 instance
    set3(1, 0, 8'h01, 0, 0, 0, 0); cyc();
    set3(1, 1, 8'h02, 0, 0, 0, 0); cyc();
    set3(1, 2, 8'h03, 0, 0, 0, 0); cyc();
    set3(1, 3, 8'h99, 1, 3, 0, 0); cyc();
    check("oor_byp_rdata", bus3.rdata_a, 8'h00);
    set3(0, 0, 0, 1, 3, 0, 0); cyc();
    check("oor_rdata_a", bus3.rdata_a, 8'h00);
    check("oor_rvalid_a", bus3.rvalid_a, 1'b1);
    set3(0, 0, 0, 1, 0, 1, 1); cyc();
    check("oor_mem0", bus3.rdata_a, R0_3);
    check("oor_mem1", bus3.rdata_b, 8'h02);
    set3(0, 0, 0, 1, 2, 0, 0); cyc();
    check("oor_mem2", bus3.rdata_a, 8'h03);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Parametrised register bank for the simple processor. Generalises the single 8-bit enabled register to DEPTH words of WIDTH bits.
- One synchronous write port and two independent registered read ports (A, B) feed the ALU operand path.
- Read outputs hold their value while their read enable is low. A same-cycle write-to-read bypass removes the one-cycle hazard.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 4, number of registers (2..2**ADDR_W; need not be a power of two)
- ADDR_W, 2, address width in bits (must satisfy 2**ADDR_W >= DEPTH)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- re_a  input  1  read enable, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  WIDTH  registered read data, port A
- rvalid_a  output  1  rdata_a updated this cycle
- re_b  input  1  read enable, port B
- raddr_b  input  ADDR_W  read address, port B
- rdata_b  output  WIDTH  registered read data, port B
- rvalid_b  output  1  rdata_b updated this cycle

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous and active-high.
- rst high at an edge:
  - all DEPTH registers <= 0
  - rdata_a, rdata_b <= 0
  - rvalid_a, rvalid_b <= 0
  - rst overrides we, re_a and re_b in the same cycle.
- Write:
  - we=1 and waddr<DEPTH at an edge: mem[waddr] <= wdata.
  - waddr>=DEPTH: write is silently dropped and no register changes.
- Read port A (port B is identical):
  - re_a=1 at an edge: rdata_a <= selected value and rvalid_a <= 1. Latency is 1 cycle from address to data.
  - Selected value:
    - wdata, if we=1 and waddr==raddr_a and raddr_a<DEPTH (write-first bypass)
    - otherwise mem[raddr_a], if raddr_a<DEPTH
    - otherwise 0 (out of range)
  - re_a=0 at an edge: rdata_a holds its previous value and rvalid_a <= 0.
- Both ports may read the same address in the same cycle. Each returns the same value, bypass included.
- No combinational path exists from any input to rdata_*/rvalid_*. All outputs are flops.
- The register contents change only through a write or reset. Reads never modify state.
- Wrap-around: none. Addresses are not taken modulo DEPTH; out-of-range accesses follow the rules above.

Optional Feature:
- Macro: REG_FILE_ZERO_R0_EN
- Defined:
  - register 0 is hardwired to zero
  - writes with waddr==0 are dropped
  - reads of address 0 return 0, including when a same-cycle write targets address 0 (no bypass)
  - no storage is inferred for entry 0
- Undefined: register 0 is an ordinary storage register.

Test Plan:
- Reset:
  - Stimulus: after arbitrary writes, assert rst for 1 cycle with we=1, re_a=1, re_b=1.
  - Required: next cycle rdata_a=rdata_b=0 and rvalid_a=rvalid_b=0; subsequent reads of addresses 0..3 all return 0x00.
- Write then read:
  - Stimulus: write 0x5A to addr 1 and 0xC3 to addr 2; then re_a=1 with raddr_a=1 and re_b=1 with raddr_b=2 in the same cycle.
  - Required: one cycle later rdata_a=0x5A, rdata_b=0xC3, rvalid_a=rvalid_b=1.
- Hold:
  - Stimulus: after the previous read, deassert re_a and re_b for 3 cycles while writing 0xFF to addr 1.
  - Required: rdata_a stays 0x5A, rvalid_a=0, rvalid_b=0 throughout.
- Bypass:
  - Stimulus: in one cycle, we=1, waddr=3, wdata=0x77, re_a=1, raddr_a=3, re_b=1, raddr_b=3.
  - Required: next cycle rdata_a=rdata_b=0x77; a later read of addr 3 also returns 0x77.
- Out of range:
  - Stimulus: DEPTH=3, ADDR_W=2; write 0x99 to addr 3, then read addr 3 on port A.
  - Required: rdata_a=0x00, rvalid_a=1, addrs 0..2 unchanged.
- Zero register:
  - Stimulus: with REG_FILE_ZERO_R0_EN defined, write 0x12 to addr 0 while reading addr 0 on port A.
  - Required: rdata_a=0x00 next cycle and on every later read.
  - Required without the macro: the same sequence returns 0x12 (bypass).
